fu_arbiter: RTL and testbench

Shares the single combinational function unit (`fu`) between two requesters, e.g. the execute stage and an address/branch helper. Each requester hands over one operation (`a`, `b`, `fs`) on a valid/ready handshake. A round-robin grant sequences it through the FU. The block returns the captured result and flags (`f`, `z`, `n`) to that requester on a valid/ready response handshake. Exactly one operation is in flight at a time.

---
 rtl/mycpu_pkg.sv | 14 +
 rtl/fu_rr_pick.sv | 16 +
 rtl/fu_arbiter.sv | 127 ++++++++++++
 tb/tb_fu_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types and defaults for the function-unit arbiter and the fu it fronts.
package mycpu_pkg;

  localparam int unsigned FU_DW       = 16;
  localparam int unsigned FU_FSW      = 4;
  localparam int unsigned FU_ARB_NREQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fu_arb_state_t;

endpackage

// File: rtl/fu_rr_pick.sv
// Two-way round-robin winner select: a lone requester wins, a tie goes to prio_in.
module fu_rr_pick
  import mycpu_pkg::*;
(
  input  logic [FU_ARB_NREQ-1:0] valid_in,
  input  logic                   prio_in,
  output logic                   win_out,
  output logic                   any_out
);

  always_comb begin
    any_out = |valid_in;
    win_out = (&valid_in) ? prio_in : valid_in[1];
  end

endmodule

// File: rtl/fu_arbiter.sv
// Shares one combinational function unit between two requesters, one operation
// in flight, round-robin grant, result returned on a per-requester handshake.
module fu_arbiter
  import mycpu_pkg::*;
#(
  parameter int unsigned DW     = FU_DW,
  parameter int unsigned FSW    = FU_FSW,
  parameter int unsigned FU_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FU_ARB_NREQ-1:0]      req_valid_in,
  output logic [FU_ARB_NREQ-1:0]      req_ready_out,
  input  logic [FU_ARB_NREQ*DW-1:0]   req_a_in,
  input  logic [FU_ARB_NREQ*DW-1:0]   req_b_in,
  input  logic [FU_ARB_NREQ*FSW-1:0]  req_fs_in,
  output logic [FU_ARB_NREQ-1:0]      rsp_valid_out,
  input  logic [FU_ARB_NREQ-1:0]      rsp_ready_in,
  output logic [DW-1:0]               rsp_f_out,
  output logic                        rsp_z_out,
  output logic                        rsp_n_out,
  output logic [DW-1:0]               fu_a_out,
  output logic [DW-1:0]               fu_b_out,
  output logic [FSW-1:0]              fu_fs_out,
  input  logic [DW-1:0]               fu_f_in,
  input  logic                        fu_z_in,
  input  logic                        fu_n_in
);

  fu_arb_state_t state_q, state_d;
  logic          prio_q, prio_d;
  logic          gnt_q, gnt_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [FSW-1:0] fs_q, fs_d;
  logic          z_q, z_d, n_q, n_d;

  logic pick_win, pick_any;

  fu_rr_pick u_pick (
    .valid_in (req_valid_in),
    .prio_in  (prio_q),
    .win_out  (pick_win),
    .any_out  (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    gnt_d         = gnt_q;
    cnt_d         = cnt_q;
    a_d           = a_q;
    b_d           = b_q;
    fs_d          = fs_q;
    f_d           = f_q;
    z_d           = z_q;
    n_d           = n_q;
    req_ready_out = '0;
    rsp_valid_out = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready_out[pick_win] = 1'b1;
          a_d     = pick_win ? req_a_in[2*DW-1:DW]    : req_a_in[DW-1:0];
          b_d     = pick_win ? req_b_in[2*DW-1:DW]    : req_b_in[DW-1:0];
          fs_d    = pick_win ? req_fs_in[2*FSW-1:FSW] : req_fs_in[FSW-1:0];
          gnt_d   = pick_win;
          cnt_d   = 3'(FU_LAT);
          prio_d  = ~pick_win;
          state_d = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        // The FU has seen stable operands for FU_LAT cycles when cnt reaches 1.
        if (cnt_q == 3'd1) begin
          f_d     = fu_f_in;
          z_d     = fu_z_in;
          n_d     = fu_n_in;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_out[gnt_q] = 1'b1;
        if (rsp_ready_in[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fs_q    <= '0;
      f_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fs_q    <= fs_d;
      f_q     <= f_d;
      z_q     <= z_d;
      n_q     <= n_d;
    end
  end

  assign fu_a_out  = a_q;
  assign fu_b_out  = b_q;
  assign fu_fs_out = fs_q;
  assign rsp_f_out = f_q;
  assign rsp_z_out = z_q;
  assign rsp_n_out = n_q;

endmodule

// File: tb/tb_fu_arbiter.sv
// Bench for fu_arbiter: transaction-level reference model plus response scoreboard,
// with a behavioural fu plant (and a delayed plant for the FU_LAT=3 instance).
module tb_fu_arbiter;
  import mycpu_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned FSW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fu_ref(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [FSW-1:0] fs);
    case (fs)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // ---------------- FU_LAT = 1 instance ----------------
  logic [1:0]       req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [2*DW-1:0]  req_a = '0, req_b = '0;
  logic [2*FSW-1:0] req_fs = '0;
  logic [DW-1:0]    rsp_f, fu_a, fu_b, fu_f;
  logic             rsp_z, rsp_n, fu_z, fu_n;
  logic [FSW-1:0]   fu_fs;

  assign fu_f = fu_ref(fu_a, fu_b, fu_fs);
  assign fu_z = (fu_f == '0);
  assign fu_n = fu_f[DW-1];

  fu_arbiter #(.DW(DW), .FSW(FSW), .FU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid), .req_ready_out(req_ready),
    .req_a_in(req_a), .req_b_in(req_b), .req_fs_in(req_fs),
    .rsp_valid_out(rsp_valid), .rsp_ready_in(rsp_ready),
    .rsp_f_out(rsp_f), .rsp_z_out(rsp_z), .rsp_n_out(rsp_n),
    .fu_a_out(fu_a), .fu_b_out(fu_b), .fu_fs_out(fu_fs),
    .fu_f_in(fu_f), .fu_z_in(fu_z), .fu_n_in(fu_n)
  );

  // ---------------- FU_LAT = 3 instance ----------------
  logic [1:0]       l3_valid = '0, l3_ready, l3_rsp_valid, l3_rsp_ready = '0;
  logic [2*DW-1:0]  l3_a = '0, l3_b = '0;
  logic [2*FSW-1:0] l3_fs = '0;
  logic [DW-1:0]    l3_rsp_f, l3_fu_a, l3_fu_b, l3_raw, l3_d1, l3_d2;
  logic             l3_rsp_z, l3_rsp_n;
  logic [FSW-1:0]   l3_fu_fs;

  assign l3_raw = fu_ref(l3_fu_a, l3_fu_b, l3_fu_fs);
  always @(posedge clk) begin
    l3_d1 <= l3_raw;
    l3_d2 <= l3_d1;
  end

  fu_arbiter #(.DW(DW), .FSW(FSW), .FU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid_in(l3_valid), .req_ready_out(l3_ready),
    .req_a_in(l3_a), .req_b_in(l3_b), .req_fs_in(l3_fs),
    .rsp_valid_out(l3_rsp_valid), .rsp_ready_in(l3_rsp_ready),
    .rsp_f_out(l3_rsp_f), .rsp_z_out(l3_rsp_z), .rsp_n_out(l3_rsp_n),
    .fu_a_out(l3_fu_a), .fu_b_out(l3_fu_b), .fu_fs_out(l3_fu_fs),
    .fu_f_in(l3_d2), .fu_z_in(l3_d2 == '0), .fu_n_in(l3_d2[DW-1])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          idx;
    logic [DW-1:0] f;
    logic          z;
    logic          n;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: one operation outstanding, ties go to whoever did not win last.
  logic           m_busy;
  logic           m_gnt;
  logic           m_last;
  int             cyc;
  int             m_rsp_cyc;
  logic [DW-1:0]  m_a, m_b;
  logic [FSW-1:0] m_fs;

  task automatic model_clear();
    m_busy = 1'b0;
    m_gnt  = 1'b0;
    m_last = 1'b1;
    m_a    = '0;
    m_b    = '0;
    m_fs   = '0;
    sb_q.delete();
  endtask

  task automatic step(input logic [1:0] v,
                      input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [FSW-1:0] s0,
                      input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [FSW-1:0] s1,
                      input logic [1:0] rr);
    logic [1:0] exp_rdy, exp_rv;
    logic       win;
    exp_t       e;
    @(negedge clk);
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_fs    = {s1, s0};
    rsp_ready = rr;
    #1;
    exp_rdy = '0;
    win     = 1'b0;
    if (!m_busy && v != 2'b00) begin
      win = (v == 2'b11) ? ~m_last : v[1];
      exp_rdy[win] = 1'b1;
    end
    exp_rv = '0;
    if (m_busy && cyc >= m_rsp_cyc) exp_rv[m_gnt] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("fu_a", 32'(fu_a), 32'(m_a));
    check("fu_b", 32'(fu_b), 32'(m_b));
    check("fu_fs", 32'(fu_fs), 32'(m_fs));
    if (exp_rv != 2'b00) begin
      if (rr[m_gnt]) m_busy = 1'b0;
    end else if (exp_rdy != 2'b00) begin
      m_a  = win ? a1 : a0;
      m_b  = win ? b1 : b0;
      m_fs = win ? s1 : s0;
      e.idx = win;
      e.f   = fu_ref(m_a, m_b, m_fs);
      e.z   = (e.f == '0);
      e.n   = e.f[DW-1];
      sb_q.push_back(e);
      m_busy    = 1'b1;
      m_gnt     = win;
      m_last    = win;
      m_rsp_cyc = cyc + 1 + 1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, '0, '0, '0, '0, '0, '0, 2'b11);
  endtask

  task automatic rand_step();
    step(2'($urandom_range(0, 3)),
         16'($urandom), 16'($urandom), 4'($urandom_range(0, 4)),
         16'($urandom), 16'($urandom), 4'($urandom_range(0, 4)),
         {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    #1;
    model_clear();
    repeat (ncyc - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_f", 32'(rsp_f), 32'd0);
    check("rst_rsp_zn", 32'({rsp_z, rsp_n}), 32'd0);
    check("rst_fu_ops", 32'({fu_a, fu_b} == '0), 32'd1);
    check("rst_fu_fs", 32'(fu_fs), 32'd0);
    check("rst_l3_out", 32'({l3_rsp_valid, l3_rsp_f, l3_fu_a}), 32'd0);
    cyc++;
  endtask

  // Response monitor: every cycle a response is shown it must match the head entry.
  initial begin : monitor
    exp_t       e;
    logic [1:0] ev;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rsp_valid != 2'b00) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e  = sb_q[0];
          ev = '0;
          ev[e.idx] = 1'b1;
          check("rsp_route", 32'(rsp_valid), 32'(ev));
          check("rsp_f", 32'(rsp_f), 32'(e.f));
          check("rsp_z", 32'(rsp_z), 32'(e.z));
          check("rsp_n", 32'(rsp_n), 32'(e.n));
          if (rsp_ready[e.idx]) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    cyc = 0;
    model_clear();
    do_reset(2);

    // Single add on requester 0, then the two flag cases on requester 1.
    step(2'b01, 16'h0003, 16'h0005, 4'd0, '0, '0, '0, 2'b11);
    idle(3);
    step(2'b10, '0, '0, '0, 16'h0005, 16'h0005, 4'd1, 2'b11);
    idle(2);
    step(2'b10, '0, '0, '0, 16'h0001, 16'h0002, 4'd1, 2'b11);
    idle(2);

    // Contention: four operations with both requesters held valid.
    repeat (12)
      step(2'b11, 16'($urandom), 16'($urandom), 4'd0, 16'($urandom), 16'($urandom), 4'd1, 2'b11);

    // Backpressure: result held for 5 cycles, non-granted ready is ignored.
    step(2'b01, 16'h8000, 16'h0001, 4'd3, '0, '0, '0, 2'b00);
    step(2'b11, 16'h1111, 16'h2222, 4'd0, 16'h3333, 16'h4444, 4'd0, 2'b00);
    repeat (2) step(2'b11, 16'h1111, 16'h2222, 4'd0, 16'h3333, 16'h4444, 4'd0, 2'b00);
    repeat (3) step(2'b11, 16'h1111, 16'h2222, 4'd0, 16'h3333, 16'h4444, 4'd0, 2'b10);
    step(2'b00, '0, '0, '0, '0, '0, '0, 2'b01);
    idle(1);

    // Reset during EXEC: operation dropped, contention restarts at requester 0.
    step(2'b10, '0, '0, '0, 16'h00AA, 16'h0055, 4'd4, 2'b11);
    do_reset(1);
    repeat (6)
      step(2'b11, 16'($urandom), 16'($urandom), 4'd2, 16'($urandom), 16'($urandom), 4'd3, 2'b11);

    repeat (400) rand_step();
    idle(4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // FU_LAT = 3: response 4 cycles after accept, operands steady meanwhile.
    @(negedge clk);
    l3_valid     = 2'b01;
    l3_a         = {16'h0000, 16'h1234};
    l3_b         = {16'h0000, 16'h0F0F};
    l3_fs        = {4'd0, 4'd1};
    l3_rsp_ready = 2'b11;
    #1;
    check("l3_ready", 32'(l3_ready), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      l3_valid = '0;
      #1;
      if (k <= 4) begin
        check("l3_fu_a", 32'(l3_fu_a), 32'h1234);
        check("l3_fu_b", 32'(l3_fu_b), 32'h0F0F);
        check("l3_fu_fs", 32'(l3_fu_fs), 32'd1);
      end
      if (k == 4) begin
        check("l3_rsp_valid", 32'(l3_rsp_valid), 32'd1);
        check("l3_rsp_f", 32'(l3_rsp_f), 32'h0325);
        check("l3_rsp_zn", 32'({l3_rsp_z, l3_rsp_n}), 32'd0);
      end else begin
        check("l3_rsp_valid", 32'(l3_rsp_valid), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
